// File: rtl/vector_write_back_queue.sv
// rtl/vector_write_back_queue.sv - in-order write-back queue between the merge stage and the VRF write port
//
// Purpose: buffers merged vector write-back entries and drains them strictly in
// order into the VRF write port, absorbing VRF stalls. Optional operand
// forwarding (youngest matching entry) is built when WB_QUEUE_FORWARD_EN is
// defined; otherwise query_hit_o/query_data_o are tied to zero.
//
// Ports:
//   clock_i        rising-edge clock
//   reset_i        synchronous reset, active-high
//   flush_i        synchronous discard of all queued entries
//   wb_valid_i     write-back entry offered
//   wb_ready_o     queue can accept an entry this cycle
//   wb_vd_addr_i   destination vreg of offered entry
//   wb_data_i      merged vd value
//   vrf_we_o       head entry presented to the VRF
//   vrf_waddr_o    head destination vreg
//   vrf_wdata_o    head data
//   vrf_ack_i      VRF accepted the head this cycle
//   query_addr_i   operand-read vreg for the forwarding check
//   query_hit_o    a queued entry targets query_addr_i
//   query_data_o   data of the youngest matching entry
//   occupancy_o    number of valid entries (0..DEPTH)

package dragonfang_pkg;
  typedef logic [31:0] data_packet_t;
endpackage

module vector_write_back_queue
  import dragonfang_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    flush_i,
  input  logic                    wb_valid_i,
  output logic                    wb_ready_o,
  input  logic [ADDR_WIDTH-1:0]   wb_vd_addr_i,
  input  data_packet_t            wb_data_i,
  output logic                    vrf_we_o,
  output logic [ADDR_WIDTH-1:0]   vrf_waddr_o,
  output data_packet_t            vrf_wdata_o,
  input  logic                    vrf_ack_i,
  input  logic [ADDR_WIDTH-1:0]   query_addr_i,
  output logic                    query_hit_o,
  output data_packet_t            query_data_o,
  output logic [$clog2(DEPTH):0]  occupancy_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  data_packet_t          data_q [DEPTH];

  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];
  assign empty    = (head_q == tail_q);
  // Same slot index but different lap: the tail has gone all the way round.
  assign full     = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

  // Outputs are forced idle while reset is held so the first reset cycle does
  // not expose stale state.
  assign wb_ready_o  = !full && !reset_i;
  assign vrf_we_o    = !empty && !reset_i;
  assign vrf_waddr_o = addr_q[head_idx];
  assign vrf_wdata_o = data_q[head_idx];
  assign occupancy_o = reset_i ? '0 : (tail_q - head_q);

  assign push = wb_valid_i && wb_ready_o;
  assign pop  = vrf_we_o && vrf_ack_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    if (flush_i) begin
      // Flush wins over any push or pop in the same cycle.
      head_d  = '0;
      tail_d  = '0;
      valid_d = '0;
    end else begin
      if (push) begin
        valid_d[tail_idx] = 1'b1;
        tail_d            = tail_q + PTR_W'(1);
      end
      if (pop) begin
        valid_d[head_idx] = 1'b0;
        head_d            = head_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
    end
  end

  // Entry storage carries no reset; valid_q and the pointers qualify it.
  always_ff @(posedge clock_i) begin
    if (push && !flush_i) begin
      addr_q[tail_idx] <= wb_vd_addr_i;
      data_q[tail_idx] <= wb_data_i;
    end
  end

`ifdef WB_QUEUE_FORWARD_EN
  // Scan from oldest to youngest so the last match seen is the youngest one.
  // The entry being offered this cycle is not yet in storage, so it is never matched.
  always_comb begin
    logic [IDX_W-1:0] idx;
    idx          = '0;
    query_hit_o  = 1'b0;
    query_data_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_idx + k[IDX_W-1:0];
      if (valid_q[idx] && (addr_q[idx] == query_addr_i)) begin
        query_hit_o  = !reset_i;
        query_data_o = data_q[idx];
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd   = ^{query_addr_i, valid_q};
  assign query_hit_o  = 1'b0;
  assign query_data_o = '0;
`endif

endmodule

// File: tb/tb_vector_write_back_queue.sv
// tb/tb_vector_write_back_queue.sv - directed self-checking bench for vector_write_back_queue

module tb_vector_write_back_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        vrf_we;
  logic [4:0]  vrf_waddr;
  logic [31:0] vrf_wdata;
  logic        vrf_ack;
  logic [4:0]  qaddr;
  logic        qhit;
  logic [31:0] qdata;
  logic [2:0]  occ;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vector_write_back_queue #(.DEPTH(4), .ADDR_WIDTH(5)) dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .flush_i      (flush),
    .wb_valid_i   (wb_valid),
    .wb_ready_o   (wb_ready),
    .wb_vd_addr_i (wb_addr),
    .wb_data_i    (wb_data),
    .vrf_we_o     (vrf_we),
    .vrf_waddr_o  (vrf_waddr),
    .vrf_wdata_o  (vrf_wdata),
    .vrf_ack_i    (vrf_ack),
    .query_addr_i (qaddr),
    .query_hit_o  (qhit),
    .query_data_o (qdata),
    .occupancy_o  (occ)
  );

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_n(input int n, input logic [4:0] a0, input logic [31:0] d0);
    for (int i = 0; i < n; i++) begin
      step();
      wb_valid = 1'b1;
      wb_addr  = a0 + 5'(i);
      wb_data  = d0 + 32'(i);
    end
    step();
    wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'h1;
    vrf_ack = 1'b0; qaddr = 5'd1;
    step(); step();
    #1;
    total++; if (wb_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b want=0", wb_ready); end
    total++; if (vrf_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b want=0", vrf_we); end
    total++; if (occ !== 3'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", occ); end
    total++; if (qhit !== 1'b0) begin bad++; $display("FAIL reset_qhit got=%0b want=0", qhit); end
    step();
    rst = 1'b0; wb_valid = 1'b0;
    #1;
    total++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%0b want=1", wb_ready); end
  endtask

  task automatic test_single();
    step();
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h11; vrf_ack = 1'b1;
    #1;
    total++; if (vrf_we !== 1'b0) begin bad++; $display("FAIL single_no_passthru got=%0b want=0", vrf_we); end
    step();
    wb_valid = 1'b0;
    #1;
    total++; if (vrf_we !== 1'b1) begin bad++; $display("FAIL single_we got=%0b want=1", vrf_we); end
    total++; if (vrf_waddr !== 5'd3) begin bad++; $display("FAIL single_addr got=%0d want=3", vrf_waddr); end
    total++; if (vrf_wdata !== 32'h11) begin bad++; $display("FAIL single_data got=%0h want=11", vrf_wdata); end
    total++; if (occ !== 3'd1) begin bad++; $display("FAIL single_occ1 got=%0d want=1", occ); end
    total++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%0b want=1", wb_ready); end
    step();
    #1;
    total++; if (occ !== 3'd0) begin bad++; $display("FAIL single_occ0 got=%0d want=0", occ); end
    total++; if (vrf_we !== 1'b0) begin bad++; $display("FAIL single_empty_we got=%0b want=0", vrf_we); end
  endtask

  task automatic test_fill_drain();
    step(); vrf_ack = 1'b0;
    push_n(4, 5'd1, 32'hA1);
    #1;
    total++; if (occ !== 3'd4) begin bad++; $display("FAIL fill_occ got=%0d want=4", occ); end
    total++; if (wb_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%0b want=0", wb_ready); end
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hA5;
    step();
    wb_valid = 1'b0;
    #1;
    total++; if (occ !== 3'd4) begin bad++; $display("FAIL fill_5th_occ got=%0d want=4", occ); end
    step();
    vrf_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (vrf_waddr !== 5'(i + 1) || vrf_wdata !== 32'hA1 + 32'(i) || vrf_we !== 1'b1) begin
        bad++; $display("FAIL drain_%0d got=%0d/%0h we=%0b want=%0d/%0h we=1", i, vrf_waddr, vrf_wdata, vrf_we, i + 1, 32'hA1 + i);
      end
      step();
    end
    #1;
    total++; if (vrf_we !== 1'b0) begin bad++; $display("FAIL drain_empty got=%0b want=0", vrf_we); end
  endtask

  task automatic test_full_push_pop();
    vrf_ack = 1'b0;
    push_n(4, 5'd10, 32'hC0);
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'hEE; vrf_ack = 1'b1;
    #1;
    total++; if (wb_ready !== 1'b0) begin bad++; $display("FAIL fullpp_ready got=%0b want=0", wb_ready); end
    step();
    wb_valid = 1'b0; vrf_ack = 1'b0;
    #1;
    total++; if (occ !== 3'd3) begin bad++; $display("FAIL fullpp_occ got=%0d want=3", occ); end
    total++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL fullpp_ready_next got=%0b want=1", wb_ready); end
    step();
    vrf_ack = 1'b1;
    for (int i = 1; i < 4; i++) begin
      #1;
      total++; if (vrf_waddr !== 5'(10 + i) || vrf_wdata !== 32'hC0 + 32'(i)) begin
        bad++; $display("FAIL fullpp_drain_%0d got=%0d/%0h want=%0d/%0h", i, vrf_waddr, vrf_wdata, 10 + i, 32'hC0 + i);
      end
      step();
    end
    #1;
    total++; if (vrf_we !== 1'b0) begin bad++; $display("FAIL fullpp_refused_leak got=%0b want=0", vrf_we); end
  endtask

  task automatic test_back_to_back();
    logic [36:0] model[$];
    vrf_ack = 1'b0;
    wb_valid = 1'b1; wb_addr = 5'd20; wb_data = 32'h100; model.push_back({5'd20, 32'h100});
    step();
    wb_addr = 5'd21; wb_data = 32'h101; model.push_back({5'd21, 32'h101});
    step();
    vrf_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wb_addr = 5'(i % 3); wb_data = 32'h200 + 32'(i);
      #1;
      total++; if (occ !== 3'd2 || {vrf_waddr, vrf_wdata} !== model[0]) begin
        bad++; $display("FAIL b2b_%0d occ=%0d head=%0h want occ=2 head=%0h", i, occ, {vrf_waddr, vrf_wdata}, model[0]);
      end
      void'(model.pop_front());
      model.push_back({5'(i % 3), 32'h200 + 32'(i)});
      step();
    end
    wb_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if ({vrf_waddr, vrf_wdata} !== model[0]) begin
        bad++; $display("FAIL b2b_tail_%0d got=%0h want=%0h", i, {vrf_waddr, vrf_wdata}, model[0]);
      end
      void'(model.pop_front());
      step();
    end
    #1;
    total++; if (occ !== 3'd0) begin bad++; $display("FAIL b2b_empty got=%0d want=0", occ); end
  endtask

  task automatic test_flush();
    vrf_ack = 1'b0;
    push_n(3, 5'd1, 32'h300);
    flush = 1'b1; wb_valid = 1'b1; wb_addr = 5'd31; wb_data = 32'hDEAD;
    step();
    flush = 1'b0; wb_valid = 1'b0;
    #1;
    total++; if (occ !== 3'd0) begin bad++; $display("FAIL flush_occ got=%0d want=0", occ); end
    total++; if (vrf_we !== 1'b0) begin bad++; $display("FAIL flush_we got=%0b want=0", vrf_we); end
    vrf_ack = 1'b1;
    step(); step();
    #1;
    total++; if (vrf_we !== 1'b0) begin bad++; $display("FAIL flush_dropped_push got=%0b want=0", vrf_we); end
  endtask

  task automatic test_forward();
    vrf_ack = 1'b0;
    step();
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'hAA;
    step(); wb_addr = 5'd5; wb_data = 32'h55;
    step(); wb_addr = 5'd7; wb_data = 32'hBB;
    step(); wb_addr = 5'd9; wb_data = 32'h99;
    qaddr = 5'd7;
    #1;
`ifdef WB_QUEUE_FORWARD_EN
    total++; if (qhit !== 1'b1 || qdata !== 32'hBB) begin bad++; $display("FAIL fwd_v7 got=%0b/%0h want=1/bb", qhit, qdata); end
    qaddr = 5'd5; #1;
    total++; if (qhit !== 1'b1 || qdata !== 32'h55) begin bad++; $display("FAIL fwd_v5 got=%0b/%0h want=1/55", qhit, qdata); end
`else
    total++; if (qhit !== 1'b0) begin bad++; $display("FAIL fwd_off_v7 got=%0b want=0", qhit); end
`endif
    qaddr = 5'd9; #1;
    total++; if (qhit !== 1'b0) begin bad++; $display("FAIL fwd_inflight_push got=%0b want=0", qhit); end
    wb_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; qaddr = 5'd7;
    #1;
    total++; if (qhit !== 1'b0) begin bad++; $display("FAIL fwd_after_flush got=%0b want=0", qhit); end
  endtask

  task automatic test_reset_midstream();
    vrf_ack = 1'b0;
    push_n(2, 5'd2, 32'h400);
    rst = 1'b1; wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h444;
    #1;
    total++; if (wb_ready !== 1'b0 || vrf_we !== 1'b0) begin
      bad++; $display("FAIL rstmid_outputs ready=%0b we=%0b want ready=0 we=0", wb_ready, vrf_we);
    end
    total++; if (occ !== 3'd0) begin bad++; $display("FAIL rstmid_occ got=%0d want=0", occ); end
    step();
    rst = 1'b0; wb_valid = 1'b0;
    #1;
    total++; if (occ !== 3'd0 || wb_ready !== 1'b1 || vrf_we !== 1'b0) begin
      bad++; $display("FAIL rstmid_after occ=%0d ready=%0b we=%0b want 0/1/0", occ, wb_ready, vrf_we);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_full_push_pop();
    test_back_to_back();
    test_flush();
    test_forward();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
